uart_mem_loader: RTL and testbench
==================================

Name: uart_mem_loader

Overview:
- Hardware program loader: the write-side counterpart to the boot ROM's read-only word store.
- Accepts a framed byte stream from the UART receiver, assembles 16-bit words big-endian, and writes them into main RAM at consecutive word addresses starting at BASE_ADDR.
- Sits between the UART RX byte interface and the RAM write port. The CPU is held off (busy) while a frame is being loaded.

Parameters:
BASE_ADDR, 32'h0000_0200, word address of the first written word (first word after the boot ROM image)
SYNC_BYTE, 8'hA5, frame start marker
TIMEOUT_CYCLES, 24'd5_000_000, maximum idle clocks between bytes inside a frame before abort

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset
rx_valid  input  1  rx_data holds a new byte this cycle
rx_data  input  8  received byte
rx_ready  output  1  loader can accept a byte; byte is consumed when rx_valid && rx_ready
mem_addr  output  32  word address of the write
mem_data  output  16  write data
mem_wr  output  1  write request, held until accepted
mem_ready  input  1  RAM accepts the write when mem_wr && mem_ready
busy  output  1  frame in progress (any state except IDLE)
done  output  1  last frame completed successfully; level signal
error  output  1  last frame aborted; level signal
words_loaded  output  16  number of words written in the current or last frame

Behaviour:
- Interface: one clock (clk). Reset (reset) is synchronous, active-low, sampled on the rising edge of clk.
- Reset values:
  - rx_ready=1, mem_wr=0, mem_addr=BASE_ADDR, mem_data=0.
  - busy=0, done=0, error=0, words_loaded=0.
  - State IDLE; timeout counter and checksum accumulator = 0.
- Frame format: SYNC_BYTE, LEN_H, LEN_L (N words, 16-bit), then N × {DATA_H, DATA_L}, then CHK_H, CHK_L (CHK only with CHECKSUM_EN).
- States and transitions:
  - IDLE: byte == SYNC_BYTE -> LEN_H; clear done, error, words_loaded, checksum. Any other byte is discarded; stay in IDLE.
  - LEN_H -> LEN_L.
  - LEN_L: if N == 0 -> FINISH; else -> DATA_H.
  - DATA_H: latch high byte -> DATA_L.
  - DATA_L: on the accepted byte, load mem_data={hi,lo}, mem_addr=BASE_ADDR+words_loaded, assert mem_wr next cycle -> WRITE.
  - WRITE:
    - rx_ready=0.
    - On mem_wr && mem_ready: deassert mem_wr next cycle, words_loaded+=1, checksum+=word (mod 2^16).
    - If words_loaded+1 == N -> CHK_H (CHECKSUM_EN) or FINISH; else -> DATA_H.
  - CHK_H -> CHK_L.
  - CHK_L: compare {CHK_H,CHK_L} to checksum; equal -> FINISH, else -> ABORT.
  - FINISH: done=1 -> IDLE (one cycle).
  - ABORT: error=1 -> IDLE (one cycle).
- rx_ready:
  - 1 in IDLE, LEN_*, DATA_*, CHK_*.
  - 0 in WRITE, FINISH, ABORT. Upstream must hold rx_valid/rx_data until accepted.
- Write handshake:
  - mem_addr and mem_data are stable while mem_wr=1.
  - mem_ready may be held low indefinitely; no timeout applies in WRITE.
  - Latency is 1 cycle from the DATA_L accept edge to mem_wr=1. If mem_ready=1 is already high, the write completes in that cycle.
- Timeout:
  - Counter clears on every accepted byte and on entry to any byte-waiting state after WRITE.
  - Counts only in LEN_H, LEN_L, DATA_H, DATA_L, CHK_H, CHK_L.
  - Reaching TIMEOUT_CYCLES-1 -> ABORT. Words already written are not rolled back; words_loaded reports the count written.
- Address arithmetic: 32-bit modular add. Wrap past 32'hFFFF_FFFF is permitted and not flagged.
- Byte value equal to SYNC_BYTE inside a frame is plain data, not a resync.
- Reset asserted mid-frame, including during WRITE with mem_wr=1: all outputs return to reset values on that edge. A partial write is abandoned; mem_wr drops immediately.
- done and error are never both 1.

Optional Feature:
CHECKSUM_EN:
- Defined: the two trailing checksum bytes are expected and verified as above; a mismatch gives error=1, done=0.
- Undefined: CHK_H/CHK_L states and the accumulator are removed; the frame ends after the last WRITE, and only a timeout can produce error.

Test Plan:
- A5 00 02 12 34 AB CD (+CHK BE 01 with CHECKSUM_EN), mem_ready tied 1 -> writes 0x1234@0x200, 0xABCD@0x201; done=1, words_loaded=2, busy falls.
- Same frame, mem_ready low for 10 cycles per write -> mem_wr held, addr/data stable, rx_ready=0 throughout, same final result.
- Bytes 00 FF A5 00 00 (+CHK 00 00) -> leading bytes ignored; N=0 gives done=1, no mem_wr ever.
- CHECKSUM_EN, frame A5 00 01 00 05 00 06 -> 0x0005 written @0x200, then error=1, done=0, words_loaded=1.
- A5 00 03 11 22 then silence for TIMEOUT_CYCLES -> one write, error=1, busy=0. A fresh A5 clears error.
- reset low during WRITE with mem_ready=0 -> next edge mem_wr=0, busy=0, words_loaded=0, rx_ready=1.

Source files
------------

// File: rtl/uart_mem_loader.sv
// uart_mem_loader: assembles a framed UART byte stream into 16-bit words and writes them to RAM.
// Define CHECKSUM_EN to expect and verify a trailing 16-bit additive checksum per frame.
module uart_mem_loader #(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0200,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd5_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic [31:0] mem_addr,
    output logic [15:0] mem_data,
    output logic        mem_wr,
    input  logic        mem_ready,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] words_loaded
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LEN_H,
        S_LEN_L,
        S_DATA_H,
        S_DATA_L,
        S_WRITE,
`ifdef CHECKSUM_EN
        S_CHK_H,
        S_CHK_L,
`endif
        S_FINISH,
        S_ABORT
    } state_t;

    localparam logic [23:0] TMO_LAST = TIMEOUT_CYCLES - 24'd1;

    state_t      state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [7:0]  hi_q, hi_d;
    logic [31:0] addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic        wr_q, wr_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [15:0] words_q, words_d;
    logic [23:0] tmr_q, tmr_d;
`ifdef CHECKSUM_EN
    logic [15:0] sum_q, sum_d;
`endif

    logic        waiting;
    logic        rdy;
    logic [15:0] words_inc;
    logic [15:0] len_rx;

    assign words_inc = words_q + 16'd1;
    assign len_rx    = {len_q[15:8], rx_data};

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            len_q   <= 16'd0;
            hi_q    <= 8'd0;
            addr_q  <= BASE_ADDR;
            data_q  <= 16'd0;
            wr_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            words_q <= 16'd0;
            tmr_q   <= 24'd0;
`ifdef CHECKSUM_EN
            sum_q   <= 16'd0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            hi_q    <= hi_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            done_q  <= done_d;
            err_q   <= err_d;
            words_q <= words_d;
            tmr_q   <= tmr_d;
`ifdef CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        hi_d    = hi_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wr_d    = wr_q;
        done_d  = done_q;
        err_d   = err_q;
        words_d = words_q;
        tmr_d   = tmr_q;
`ifdef CHECKSUM_EN
        sum_d   = sum_q;
`endif
        rdy     = 1'b0;
        waiting = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                rdy = 1'b1;
                if (rx_valid && rx_data == SYNC_BYTE) begin
                    state_d = S_LEN_H;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    words_d = 16'd0;
                    tmr_d   = 24'd0;
`ifdef CHECKSUM_EN
                    sum_d   = 16'd0;
`endif
                end
            end
            S_LEN_H: begin
                rdy     = 1'b1;
                waiting = 1'b1;
                if (rx_valid) begin
                    len_d[15:8] = rx_data;
                    state_d     = S_LEN_L;
                end
            end
            S_LEN_L: begin
                rdy     = 1'b1;
                waiting = 1'b1;
                if (rx_valid) begin
                    len_d[7:0] = rx_data;
                    if (len_rx == 16'd0) begin
                        state_d = S_FINISH;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_DATA_H;
                    end
                end
            end
            S_DATA_H: begin
                rdy     = 1'b1;
                waiting = 1'b1;
                if (rx_valid) begin
                    hi_d    = rx_data;
                    state_d = S_DATA_L;
                end
            end
            S_DATA_L: begin
                rdy     = 1'b1;
                waiting = 1'b1;
                if (rx_valid) begin
                    data_d  = {hi_q, rx_data};
                    addr_d  = BASE_ADDR + {16'd0, words_q};
                    wr_d    = 1'b1;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                // No timeout here: the RAM may stall for as long as it likes.
                if (wr_q && mem_ready) begin
                    wr_d    = 1'b0;
                    words_d = words_inc;
                    tmr_d   = 24'd0;
`ifdef CHECKSUM_EN
                    sum_d   = sum_q + data_q;
`endif
                    if (words_inc == len_q) begin
`ifdef CHECKSUM_EN
                        state_d = S_CHK_H;
`else
                        state_d = S_FINISH;
                        done_d  = 1'b1;
`endif
                    end else begin
                        state_d = S_DATA_H;
                    end
                end
            end
`ifdef CHECKSUM_EN
            S_CHK_H: begin
                rdy     = 1'b1;
                waiting = 1'b1;
                if (rx_valid) begin
                    hi_d    = rx_data;
                    state_d = S_CHK_L;
                end
            end
            S_CHK_L: begin
                rdy     = 1'b1;
                waiting = 1'b1;
                if (rx_valid) begin
                    if ({hi_q, rx_data} == sum_q) begin
                        state_d = S_FINISH;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_ABORT;
                        err_d   = 1'b1;
                    end
                end
            end
`endif
            S_FINISH: state_d = S_IDLE;
            S_ABORT:  state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        // Inter-byte timer; an accepted byte always restarts it.
        if (waiting) begin
            if (rx_valid) begin
                tmr_d = 24'd0;
            end else if (tmr_q == TMO_LAST) begin
                tmr_d   = 24'd0;
                state_d = S_ABORT;
                err_d   = 1'b1;
            end else begin
                tmr_d = tmr_q + 24'd1;
            end
        end
    end

    assign rx_ready     = rdy;
    assign mem_addr     = addr_q;
    assign mem_data     = data_q;
    assign mem_wr       = wr_q;
    assign busy         = (state_q != S_IDLE);
    assign done         = done_q;
    assign error        = err_q;
    assign words_loaded = words_q;

    a_done_err_excl: assert property (
        @(posedge clk) disable iff (!reset) !(done_q && err_q)
    );

endmodule

// File: tb/tb_uart_mem_loader.sv
// Directed bench for uart_mem_loader: frame-level model plus per-cycle write scoreboard.
// Works with or without CHECKSUM_EN defined.
module tb_uart_mem_loader;

    localparam logic [31:0] BASE = 32'h0000_0200;
    localparam logic [7:0]  SYNC = 8'hA5;
    localparam int          TMO  = 40;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready;
    logic [31:0] mem_addr;
    logic [15:0] mem_data;
    logic        mem_wr;
    logic        mem_ready = 1'b1;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    uart_mem_loader #(
        .BASE_ADDR(BASE),
        .SYNC_BYTE(SYNC),
        .TIMEOUT_CYCLES(24'd40)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rx_valid(rx_valid),
        .rx_data(rx_data),
        .rx_ready(rx_ready),
        .mem_addr(mem_addr),
        .mem_data(mem_data),
        .mem_wr(mem_wr),
        .mem_ready(mem_ready),
        .busy(busy),
        .done(done),
        .error(error),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    logic [7:0]  stim[$];
    logic [47:0] expq[$];

    int          stall = 0;
    bit          hold_low = 1'b0;
    int          scnt = 0;
    int          stall_seen = 0;
    int          nwrites = 0;
    logic [31:0] last_addr = 32'h0;
    logic [15:0] last_data = 16'h0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Frame-level reference: what a correct loader must write and report.
    task automatic model(output bit e_done, output bit e_err, output int e_words);
        int i = 0;
        int n;
        int pos;
        logic [15:0] sum = 16'h0;
        logic [15:0] w;
        e_done = 1'b0;
        e_err = 1'b0;
        e_words = 0;
        while (i < stim.size() && stim[i] != SYNC) i++;
        if (i + 2 >= stim.size()) begin
            e_err = (i < stim.size());
            return;
        end
        n = int'({stim[i+1], stim[i+2]});
        pos = i + 3;
        for (int k = 0; k < n; k++) begin
            if (pos + 1 >= stim.size()) break;
            w = {stim[pos], stim[pos+1]};
            expq.push_back({BASE + 32'(k), w});
            sum += w;
            e_words++;
            pos += 2;
        end
        if (e_words < n) begin
            e_err = 1'b1;
            return;
        end
`ifdef CHECKSUM_EN
        if (n != 0) begin
            if (pos + 1 >= stim.size()) begin
                e_err = 1'b1;
                return;
            end
            if ({stim[pos], stim[pos+1]} != sum) begin
                e_err = 1'b1;
                return;
            end
        end
`endif
        e_done = 1'b1;
    endtask

    always @(negedge clk) begin
        if (hold_low) begin
            mem_ready = 1'b0;
        end else if (!mem_wr) begin
            scnt = 0;
            mem_ready = (stall == 0);
        end else if (scnt < stall) begin
            scnt++;
            mem_ready = 1'b0;
        end else begin
            mem_ready = 1'b1;
        end
    end

    logic        p_wr = 1'b0;
    logic        p_rdy = 1'b0;
    logic        p_rst = 1'b0;
    logic [31:0] p_addr = 32'h0;
    logic [15:0] p_data = 16'h0;
    logic [31:0] e_addr;
    logic [15:0] e_data;

    initial begin : monitor
        forever begin
            @(negedge clk);
            #1;
            if (p_wr && !p_rdy && p_rst) begin
                chk("wr_held", mem_wr, 1);
                chk("addr_stable", mem_addr, p_addr);
                chk("data_stable", mem_data, p_data);
            end
            if (mem_wr) chk("rx_ready_in_write", rx_ready, 0);
            chk("done_err_excl", done & error, 0);
            if (mem_wr && !mem_ready) stall_seen++;
            if (mem_wr && mem_ready && reset) begin
                if (expq.size() == 0) begin
                    nvec++;
                    nerr++;
                    $display("FAIL unexpected_write: got %0h@%0h, expected none",
                             mem_data, mem_addr);
                end else begin
                    {e_addr, e_data} = expq.pop_front();
                    chk("wr_addr", mem_addr, e_addr);
                    chk("wr_data", mem_data, {16'h0, e_data});
                end
                nwrites++;
                last_addr = mem_addr;
                last_data = mem_data;
            end
            p_wr = mem_wr;
            p_rdy = mem_ready;
            p_rst = reset;
            p_addr = mem_addr;
            p_data = mem_data;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_valid = 1'b1;
        rx_data = b;
        while (!rx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("byte_accepted", rx_ready, 1);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input int lim);
        int n = 0;
        while (busy && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", busy, 0);
    endtask

    task automatic finish_frame(input int lim, input bit ed, input bit ee,
                                input int ew);
        wait_idle(lim);
        chk("done", done, ed);
        chk("error", error, ee);
        chk("words", words_loaded, ew);
        chk("rx_ready_idle", rx_ready, 1);
        chk("wr_idle", mem_wr, 0);
        chk("writes_left", expq.size(), 0);
    endtask

    task automatic run_frame(input int lim);
        bit ed;
        bit ee;
        int ew;
        model(ed, ee, ew);
        foreach (stim[i]) send_byte(stim[i]);
        finish_frame(lim, ed, ee, ew);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        bit ed;
        bit ee;
        int ew;

        repeat (3) @(negedge clk);
        chk("rst_rx_ready", rx_ready, 1);
        chk("rst_mem_wr", mem_wr, 0);
        chk("rst_mem_addr", mem_addr, BASE);
        chk("rst_mem_data", mem_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_words", words_loaded, 0);
        reset = 1'b1;
        @(negedge clk);

        // Two words, RAM always ready
        stim = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
`ifdef CHECKSUM_EN
        stim.push_back(8'hBE);
        stim.push_back(8'h01);
`endif
        nwrites = 0;
        run_frame(50);
        chk("f1_nwrites", nwrites, 2);
        chk("f1_last_addr", last_addr, 32'h0000_0201);
        chk("f1_last_data", last_data, 16'hABCD);
        chk("f1_done_lit", done, 1);
        chk("f1_words_lit", words_loaded, 2);

        // Same frame, RAM stalls 10 cycles per write
        stall = 10;
        stall_seen = 0;
        run_frame(100);
        chk("f2_stall_cycles", stall_seen, 20);
        stall = 0;

        // Leading junk, zero-length frame
        stim = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00};
`ifdef CHECKSUM_EN
        stim.push_back(8'h00);
        stim.push_back(8'h00);
`endif
        nwrites = 0;
        run_frame(50);
        chk("f3_no_writes", nwrites, 0);
        chk("f3_done_lit", done, 1);

        // One word, wrong checksum when checksums are on
        stim = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h05, 8'h00, 8'h06};
        run_frame(50);
        chk("f4_last_data", last_data, 16'h0005);
        chk("f4_last_addr", last_addr, BASE);
`ifdef CHECKSUM_EN
        chk("f4_error_lit", error, 1);
        chk("f4_done_lit", done, 0);
        chk("f4_words_lit", words_loaded, 1);
`endif

        // Sync value used as data
        stim = '{8'hA5, 8'h00, 8'h01, 8'hA5, 8'hA5};
`ifdef CHECKSUM_EN
        stim.push_back(8'hA5);
        stim.push_back(8'hA5);
`endif
        run_frame(50);
        chk("f5_last_data", last_data, 16'hA5A5);

        // Truncated frame aborts after the inter-byte timeout
        stim = '{8'hA5, 8'h00, 8'h03, 8'h11, 8'h22};
        model(ed, ee, ew);
        foreach (stim[i]) send_byte(stim[i]);
        repeat (TMO) @(negedge clk);
        chk("tmo_not_yet_err", error, 0);
        chk("tmo_not_yet_busy", busy, 1);
        @(negedge clk);
        chk("tmo_err_now", error, 1);
        finish_frame(20, ed, ee, ew);
        chk("tmo_error_lit", error, 1);
        chk("tmo_words_lit", words_loaded, 1);

        // A fresh sync clears the previous error
        send_byte(8'hA5);
        chk("resync_error", error, 0);
        chk("resync_done", done, 0);
        chk("resync_words", words_loaded, 0);
        chk("resync_busy", busy, 1);
        send_byte(8'h00);
        send_byte(8'h00);
        wait_idle(20);
        chk("resync_done_end", done, 1);

        // Reset while a write is pending
        hold_low = 1'b1;
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'h12);
        send_byte(8'h34);
        chk("wr_latency", mem_wr, 1);
        repeat (3) @(negedge clk);
        chk("wr_still_pending", mem_wr, 1);
        chk("pending_data", mem_data, 16'h1234);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_mem_wr", mem_wr, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_words", words_loaded, 0);
        chk("mid_rst_rx_ready", rx_ready, 1);
        chk("mid_rst_data", mem_data, 0);
        chk("mid_rst_addr", mem_addr, BASE);
        reset = 1'b1;
        hold_low = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_writes_left", expq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
